// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo_if
//  Description : Producer-side push/status and uart_tx handshake bundle for
//                uart_tx_fifo. slave = the FIFO, master = the surroundings.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_fifo_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) ();
    // producer side
    logic              i_wr_en;
    logic [DATA_W-1:0] i_wr_data;
    logic              i_clr_ovf;
    logic              o_full;
    logic              o_empty;
    logic [ADDR_W:0]   o_count;
    logic              o_overflow;
    // uart_tx side
    logic              o_start_tx;
    logic [DATA_W-1:0] o_tx_data;
    logic              i_tx_busy;
    logic              i_tx_done;

    modport slave (
        input  i_wr_en, i_wr_data, i_clr_ovf, i_tx_busy, i_tx_done,
        output o_full, o_empty, o_count, o_overflow, o_start_tx, o_tx_data
    );

    modport master (
        output i_wr_en, i_wr_data, i_clr_ovf, i_tx_busy, i_tx_done,
        input  o_full, o_empty, o_count, o_overflow, o_start_tx, o_tx_data
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Byte FIFO plus transmit sequencer feeding uart_tx. Bytes are
//                popped one at a time and launched with a one-cycle start
//                pulse; the next launch waits for done and an idle uart_tx.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  wire logic    clk,
    input  wire logic    i_rst_n,
    uart_tx_fifo_if.slave bus
);
    localparam int              DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_start_tx;
    logic [DATA_W-1:0] r_tx_data;
    state_t            r_state;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Full/empty decode only from the registered count, so no input reaches
    // an output combinationally.
    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);
    // A push while full is dropped even if a pop happens on the same edge.
    assign w_push  = bus.i_wr_en && !w_full;
    // The only pop point is the IDLE->START launch.
    assign w_pop   = (r_state == S_IDLE) && !w_empty && !bus.i_tx_busy;

    assign bus.o_full     = w_full;
    assign bus.o_empty    = w_empty;
    assign bus.o_count    = r_count;
    assign bus.o_overflow = r_overflow;
    assign bus.o_start_tx = r_start_tx;
    assign bus.o_tx_data  = r_tx_data;

    // Storage array; contents are don't-care after reset, so it has no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.i_wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks push/pop balance.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow <= 1'b0;
        end else if (bus.i_wr_en && w_full) begin
            r_overflow <= 1'b1;
        end else if (bus.i_clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    // Launch sequencer with registered start pulse and held transmit byte.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_start_tx <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_start_tx <= 1'b0;
                    if (w_pop) begin
                        r_tx_data  <= r_mem[r_rd_ptr];
                        r_start_tx <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    // done is ignored here; uart_tx has only just seen start
                    r_start_tx <= 1'b0;
                    r_state    <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    r_start_tx <= 1'b0;
                    if (bus.i_tx_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_start_tx <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Self-checking bench for uart_tx_fifo with a behavioural
//                uart_tx stand-in and a byte scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;
    localparam int FRAME = 20;

    logic clk = 1'b0;
    logic rst_n;
    logic force_busy;
    logic model_busy;
    logic model_done;
    logic frame_lost;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_launch = 0;
    int   last_launch;
    logic last_valid;
    logic prev_start;
    logic [7:0] cur_byte;
    int   frame_cnt;
    logic [7:0] exp_q [$];

    uart_tx_fifo_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    assign bus.i_tx_busy = model_busy | force_busy;
    assign bus.i_tx_done = model_done;

    uart_tx_fifo #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // uart_tx stand-in and launch monitor, evaluated on falling edges
    initial begin
        model_busy  = 1'b0;
        model_done  = 1'b0;
        frame_lost  = 1'b0;
        last_valid  = 1'b0;
        prev_start  = 1'b0;
        last_launch = 0;
        cur_byte    = 8'h00;
        frame_cnt   = 0;
        forever begin
            @(negedge clk);
            cyc++;
            model_done = 1'b0;
            if (prev_start) check("pulse_len", {31'd0, bus.o_start_tx}, 32'd0);
            prev_start = bus.o_start_tx;
            if (bus.o_start_tx) begin
                n_launch++;
                check("launch_while_busy", {31'd0, model_busy}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_launch", {24'd0, bus.o_tx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("tx_data", {24'd0, bus.o_tx_data}, {24'd0, exp_q.pop_front()});
                end
                if (last_valid) check("gap", {31'd0, (cyc - last_launch) > FRAME}, 32'd1);
                last_launch = cyc;
                last_valid  = 1'b1;
                cur_byte    = bus.o_tx_data;
                model_busy  = 1'b1;
                frame_lost  = 1'b0;
                frame_cnt   = FRAME;
            end else if (model_busy) begin
                frame_cnt--;
                if (frame_cnt == 0) begin
                    if (!frame_lost) check("hold", {24'd0, bus.o_tx_data}, {24'd0, cur_byte});
                    model_busy = 1'b0;
                    model_done = 1'b1;
                    frame_lost = 1'b0;
                end
            end
        end
    end

    task automatic wait_drain(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !model_busy && !model_done && bus.o_empty) begin
                ok = 1'b1;
                break;
            end
        end
        check({"drain_", tag}, {31'd0, ok}, 32'd1);
    endtask

    task automatic push_burst(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_wr_en   = 1'b1;
            bus.i_wr_data = first + 8'(i);
            exp_q.push_back(first + 8'(i));
            @(negedge clk);
        end
        bus.i_wr_en = 1'b0;
    endtask

    initial begin
        int target;
        logic ok;
        rst_n         = 1'b0;
        force_busy    = 1'b0;
        bus.i_wr_en   = 1'b0;
        bus.i_wr_data = 8'h00;
        bus.i_clr_ovf = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_empty", {31'd0, bus.o_empty}, 32'd1);
        check("rst_full", {31'd0, bus.o_full}, 32'd0);
        check("rst_count", {27'd0, bus.o_count}, 32'd0);
        check("rst_ovf", {31'd0, bus.o_overflow}, 32'd0);
        check("rst_start", {31'd0, bus.o_start_tx}, 32'd0);
        check("rst_data", {24'd0, bus.o_tx_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single byte: launch one edge after the accept edge
        bus.i_wr_en   = 1'b1;
        bus.i_wr_data = 8'hAB;
        exp_q.push_back(8'hAB);
        @(negedge clk);
        bus.i_wr_en = 1'b0;
        check("lat_nostart", {31'd0, bus.o_start_tx}, 32'd0);
        check("lat_count1", {27'd0, bus.o_count}, 32'd1);
        @(negedge clk);
        check("lat_start", {31'd0, bus.o_start_tx}, 32'd1);
        check("lat_data", {24'd0, bus.o_tx_data}, 32'hAB);
        check("lat_count0", {27'd0, bus.o_count}, 32'd0);
        wait_drain("single");

        // burst: first byte leaves immediately, count peaks at 4
        push_burst(8'h01, 5);
        check("burst_peak", {27'd0, bus.o_count}, 32'd4);
        wait_drain("burst");

        // fill to full with launches held off, then overflow
        force_busy = 1'b1;
        push_burst(8'h10, 16);
        check("full_flag", {31'd0, bus.o_full}, 32'd1);
        check("full_count", {27'd0, bus.o_count}, 32'd16);
        check("ovf_before", {31'd0, bus.o_overflow}, 32'd0);
        bus.i_wr_en   = 1'b1;
        bus.i_wr_data = 8'h20;
        @(negedge clk);
        bus.i_wr_en = 1'b0;
        check("ovf_set", {31'd0, bus.o_overflow}, 32'd1);
        check("ovf_count", {27'd0, bus.o_count}, 32'd16);
        bus.i_wr_en   = 1'b1;
        bus.i_wr_data = 8'h21;
        bus.i_clr_ovf = 1'b1;
        @(negedge clk);
        bus.i_wr_en = 1'b0;
        check("ovf_set_wins", {31'd0, bus.o_overflow}, 32'd1);
        @(negedge clk);
        bus.i_clr_ovf = 1'b0;
        check("ovf_clr", {31'd0, bus.o_overflow}, 32'd0);
        check("ovf_full_kept", {31'd0, bus.o_full}, 32'd1);
        force_busy = 1'b0;
        wait_drain("full");

        // wrap-around: three drained rounds of 12
        for (int r = 0; r < 3; r++) begin
            push_burst(8'h80 + 8'(r * 12), 12);
            wait_drain("wrap");
        end

        // simultaneous push and pop with two entries queued
        force_busy = 1'b1;
        push_burst(8'h40, 2);
        bus.i_wr_en   = 1'b1;
        bus.i_wr_data = 8'h42;
        exp_q.push_back(8'h42);
        force_busy    = 1'b0;
        @(negedge clk);
        bus.i_wr_en = 1'b0;
        check("pp_count", {27'd0, bus.o_count}, 32'd2);
        check("pp_start", {31'd0, bus.o_start_tx}, 32'd1);
        wait_drain("pushpop");

        // reset during the second of four frames
        target = n_launch + 2;
        push_burst(8'h50, 4);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (n_launch >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("second_launch", {31'd0, ok}, 32'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        frame_lost = model_busy;
        last_valid = 1'b0;
        #1;
        check("mid_rst_count", {27'd0, bus.o_count}, 32'd0);
        check("mid_rst_empty", {31'd0, bus.o_empty}, 32'd1);
        check("mid_rst_data", {24'd0, bus.o_tx_data}, 32'd0);
        check("mid_rst_start", {31'd0, bus.o_start_tx}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", {31'd0, model_busy}, 32'd1);
        push_burst(8'h77, 1);
        repeat (2) @(negedge clk);
        check("no_launch_busy", {27'd0, bus.o_count}, 32'd1);
        wait_drain("reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // absolute watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte FIFO with a transmit sequencer that sits directly upstream of uart_tx. Producers push bytes at clock rate. The block drains the bytes one at a time into uart_tx using uart_tx's i_start_tx/i_data inputs and its o_busy/o_done outputs, so software-side logic never waits on the serial line. The block uses the uart_tx clock domain and never touches the line itself.

Parameters:
ADDR_W, 4, log2 of FIFO depth; DEPTH = 2**ADDR_W = 16 entries
DATA_W, 8, byte width; must match uart_tx i_data

Ports:
clk  input  1  system clock, shared with uart_tx
i_rst_n  input  1  asynchronous active-low reset
i_wr_en  input  1  push request, sampled on rising clk
i_wr_data  input  DATA_W  byte to push
i_clr_ovf  input  1  clears sticky o_overflow
o_full  output  1  FIFO holds DEPTH entries
o_empty  output  1  FIFO holds 0 entries
o_count  output  ADDR_W+1  current occupancy, 0..DEPTH
o_overflow  output  1  sticky: a push was dropped while full
o_start_tx  output  1  one-cycle launch pulse to uart_tx i_start_tx
o_tx_data  output  DATA_W  byte to uart_tx i_data; held stable from launch until done
i_tx_busy  input  1  from uart_tx o_busy
i_tx_done  input  1  from uart_tx o_done

Behaviour:
- Reset (async assert, sync release): rd/wr pointers and count go to 0, o_empty=1, o_full=0, o_overflow=0, o_start_tx=0, o_tx_data=0, FSM=IDLE. Memory contents are don't-care.
- Storage: circular buffer, ADDR_W-bit rd/wr pointers that wrap DEPTH-1 -> 0. o_count is a registered counter. o_full=(count==DEPTH), o_empty=(count==0).
- Push: if i_wr_en && !o_full, write mem[wr] and increment wr at the edge.
- Push when full: the byte is dropped, pointers are unchanged, and o_overflow is set at that edge. A push that coincides with a pop while full is also dropped; there is no bypass.
- o_overflow stays high until i_clr_ovf=1 or reset. If a set and i_clr_ovf happen in the same cycle, the set wins.
- Pop occurs only on the FSM IDLE->START transition.
- Simultaneous push+pop: count is unchanged and both pointers advance.
- FSM states: IDLE, START, WAIT_DONE. All outputs are registered.
  - IDLE -> START when !o_empty && !i_tx_busy. At this edge: o_tx_data <= mem[rd], rd++, count--, o_start_tx <= 1.
  - START -> WAIT_DONE unconditionally. o_start_tx <= 0, so the pulse lasts exactly one clk period.
  - WAIT_DONE -> IDLE on i_tx_done==1. i_tx_done is ignored while in START.
- Latency: a byte pushed into an empty FIFO with the FSM in IDLE and uart_tx idle gives o_start_tx high in the cycle immediately after the push-accept edge (push at edge E0, launch edge E1).
- Back-to-back frames: the next launch comes no earlier than the cycle after i_tx_done is seen, and also requires i_tx_busy low.
- o_tx_data changes only on IDLE->START.
- Reset mid-frame: FIFO contents are lost and the FSM returns to IDLE. uart_tx has no reset and finishes its frame; the i_tx_busy check in IDLE blocks the next launch until the line is idle.
- No combinational path from any input to any output.

Test Plan:
- Single byte: reset, push 0xAB once with uart_tx CLK_PER_BIT=87 -> o_start_tx high for exactly 1 cycle, one edge after the push. o_tx_data=0xAB until i_tx_done. uart_rx o_data=0xAB. o_empty=1 afterwards.
- Burst ordering: push 0x01..0x05 on consecutive cycles -> o_count peaks at 4 (the first byte pops immediately). uart_rx receives 0x01,0x02,0x03,0x04,0x05 in order. Launches are spaced by at least one full frame (>=870 clk).
- Full/overflow: hold launch off (i_tx_busy forced 1), push 17 bytes 0x10..0x20 -> o_full=1 and o_count=16 after the 16th push. 0x20 is dropped and o_overflow=1 until i_clr_ovf. After release, 0x10..0x1F are sent.
- Wrap-around: 3 rounds of 12 pushes, each fully drained -> pointers wrap and all 36 bytes arrive in order with no loss.
- Simultaneous push+pop: with count=2, push on the IDLE->START edge -> o_count stays 2 and the pushed byte is sent last.
- Reset mid-frame: assert i_rst_n=0 for 3 cycles during frame 2 of 4 -> outputs go to reset values immediately. No o_start_tx while i_tx_busy=1. A byte pushed after reset launches only after uart_tx o_done.
